// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// The key map is indexed by {row, col} as seen by the scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      StScan,
      StDebounce,
      StPressed,
      StRelease
   } state_e;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1,     4'h2, 4'h3,     4'hA,
      4'h4,     4'h5, 4'h6,     4'hB,
      4'h7,     4'h8, 4'h9,     4'hC,
      KEY_STAR, 4'h0, KEY_HASH, 4'hD
   };

   // True when exactly one active-low column is pulled down.
   function automatic logic one_cold(input logic [3:0] c);
      case (c)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_cold = 1'b1;
         default:                            one_cold = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] c);
      case (c)
         4'b1110: col_index = 2'd0;
         4'b1101: col_index = 2'd1;
         4'b1011: col_index = 2'd2;
         default: col_index = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for signals asynchronous to clk.
module sync2 #(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         meta_q <= RST_VAL;
         q      <= RST_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, debounce, one-cycle key strobe and an
// eight-digit shift register feeding the seven-segment display.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned DIV_W        = 18,
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [3:0]  col,
   input  logic        digit_clr,
   output logic [3:0]  row,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [31:0] digits
);

   localparam int unsigned CNT_W = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
   // The detecting tick counts as the first match, so the last step is from DEBOUNCE_CNT-2.
   localparam logic [CNT_W-1:0] CNT_PEN = CNT_W'(DEBOUNCE_CNT - 2);

   logic [3:0]       col_s;
   logic [DIV_W-1:0] div_q;
   logic             tick;
   state_e           state_q, state_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       col_lat_q, col_lat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, release_done;

   sync2 #(
      .WIDTH   (4),
      .RST_VAL (4'hF)
   ) u_col_sync (
      .clk   (clk),
      .clr_n (clr_n),
      .d     (col),
      .q     (col_s)
   );

   assign tick = &div_q;

   always_comb begin
      state_d      = state_q;
      row_idx_d    = row_idx_q;
      col_idx_d    = col_idx_q;
      col_lat_d    = col_lat_q;
      cnt_d        = cnt_q;
      accept       = 1'b0;
      release_done = 1'b0;
      if (tick) begin
         unique case (state_q)
            StScan: begin
               if (one_cold(col_s)) begin
                  col_lat_d = col_s;
                  col_idx_d = col_index(col_s);
                  cnt_d     = '0;
                  state_d   = StDebounce;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
            StDebounce: begin
               if (col_s == col_lat_q) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_PEN) begin
                     state_d = StPressed;
                     accept  = 1'b1;
                  end
               end else begin
                  state_d   = StScan;
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
            StPressed: begin
               if (col_s == 4'hF) begin
                  cnt_d   = '0;
                  state_d = StRelease;
               end
            end
            StRelease: begin
               if (col_s == 4'hF) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_PEN) begin
                     state_d      = StScan;
                     row_idx_d    = row_idx_q + 2'd1;
                     release_done = 1'b1;
                  end
               end else begin
                  state_d = StPressed;
               end
            end
            default: state_d = StScan;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         div_q     <= '0;
         state_q   <= StScan;
         row_idx_q <= 2'd0;
         col_idx_q <= 2'd0;
         col_lat_q <= 4'hF;
         cnt_q     <= '0;
         row       <= 4'b1110;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         key_held  <= 1'b0;
         digits    <= '0;
      end else begin
         div_q     <= div_q + DIV_W'(1);
         state_q   <= state_d;
         row_idx_q <= row_idx_d;
         col_idx_q <= col_idx_d;
         col_lat_q <= col_lat_d;
         cnt_q     <= cnt_d;
         row       <= ~(4'b0001 << row_idx_d);
         key_valid <= accept;
         if (accept) begin
            key_code <= KEY_MAP[{row_idx_q, col_idx_q}];
            key_held <= 1'b1;
         end else if (release_done) begin
            key_held <= 1'b0;
         end
         // Shift the code committed on the strobe cycle; a clear wins over it.
         if (digit_clr) begin
            digits <= '0;
         end else if (key_valid) begin
            digits <= {digits[27:0], key_code};
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a row-aware keypad model on col.
module tb_keypad_scanner;

   localparam int unsigned DIV_W = 4;
   localparam int unsigned DBC   = 4;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        digit_clr = 1'b0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [31:0] digits;

   int checks = 0;
   int errors = 0;
   int vcount = 0;
   int wide   = 0;
   logic prev_valid = 1'b0;

   logic       kdown = 1'b0;
   logic [1:0] krow  = 2'd0;
   logic [3:0] kmask = 4'hF;
   logic [DIV_W-1:0] tdiv;

   always #5 clk = ~clk;

   // Pressed key pulls its columns low only while its row is driven.
   assign col = (kdown && row == ~(4'b0001 << krow)) ? kmask : 4'hF;

   keypad_scanner #(
      .DIV_W        (DIV_W),
      .DEBOUNCE_CNT (DBC)
   ) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .col       (col),
      .digit_clr (digit_clr),
      .row       (row),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_held  (key_held),
      .digits    (digits)
   );

   // Independent divider model: a tick edge follows every cycle with tdiv all ones.
   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) tdiv <= '0;
      else        tdiv <= tdiv + 1'b1;
   end

   always @(negedge clk) begin
      if (!clr_n) begin
         prev_valid <= 1'b0;
      end else begin
         if (key_valid) vcount <= vcount + 1;
         if (key_valid && prev_valid) wide <= wide + 1;
         prev_valid <= key_valid;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_tick();
      int n = 0;
      while (tdiv != '1 && n < 40) begin
         step();
         n++;
      end
      step();
   endtask

   task automatic wait_row(input logic [1:0] r);
      int n = 0;
      logic [3:0] exp_row;
      exp_row = ~(4'b0001 << r);
      while (row !== exp_row && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (row !== exp_row) begin
         errors++;
         $display("FAIL wait_row: row=%b required %b", row, exp_row);
      end
   endtask

   task automatic press_key(input logic [1:0] r, input logic [3:0] m, input logic [3:0] exp_code);
      int v0 = vcount;
      int n = 0;
      krow  = r;
      kmask = m;
      kdown = 1'b1;
      while (vcount == v0 && n < 300) begin
         step();
         n++;
      end
      checks++;
      if (vcount != v0 + 1 || key_code !== exp_code) begin
         errors++;
         $display("FAIL press_key: pulses=%0d code=%h required pulses=1 code=%h",
                  vcount - v0, key_code, exp_code);
      end
      wait_tick();
      kdown = 1'b0;
      repeat (6) wait_tick();
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      repeat (3) step();
      checks++;
      if (row !== 4'b1110) begin
         errors++; $display("FAIL reset_row: row=%b required 1110", row);
      end
      checks++;
      if (digits !== 32'h0) begin
         errors++; $display("FAIL reset_digits: digits=%h required 0", digits);
      end
      checks++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: valid=%b held=%b required 0 0", key_valid, key_held);
      end
      checks++;
      if (key_code !== 4'h0) begin
         errors++; $display("FAIL reset_code: code=%h required 0", key_code);
      end
      clr_n = 1'b1;
      step();
   endtask

   task automatic test_single_press();
      int v0;
      int n = 0;
      wait_row(2'd1);
      v0 = vcount;
      krow = 2'd1; kmask = 4'b1011; kdown = 1'b1;
      while (vcount == v0 && n < 300) begin
         step();
         n++;
      end
      checks++;
      if (key_code !== 4'h6 || key_held !== 1'b1) begin
         errors++;
         $display("FAIL single_code: code=%h held=%b required 6 1", key_code, key_held);
      end
      repeat (2) step();
      checks++;
      if (digits !== 32'h00000006) begin
         errors++; $display("FAIL single_digits: digits=%h required 00000006", digits);
      end
      wait_tick();
      kdown = 1'b0;
      repeat (3) wait_tick();
      checks++;
      if (key_held !== 1'b1) begin
         errors++; $display("FAIL held_early: held=%b required 1", key_held);
      end
      wait_tick();
      checks++;
      if (key_held !== 1'b0) begin
         errors++; $display("FAIL held_drop: held=%b required 0", key_held);
      end
      checks++;
      if (vcount != v0 + 1) begin
         errors++; $display("FAIL single_pulses: pulses=%0d required 1", vcount - v0);
      end
   endtask

   task automatic test_bounce();
      int v0;
      wait_row(2'd1);
      v0 = vcount;
      krow = 2'd1; kmask = 4'b1110; kdown = 1'b1;
      repeat (2) wait_tick();
      checks++;
      if (row !== 4'b1101) begin
         errors++; $display("FAIL bounce_frozen: row=%b required 1101", row);
      end
      kdown = 1'b0;
      wait_tick();
      checks++;
      if (row !== 4'b1011) begin
         errors++; $display("FAIL bounce_resume: row=%b required 1011", row);
      end
      repeat (5) wait_tick();
      checks++;
      if (vcount != v0) begin
         errors++; $display("FAIL bounce_pulse: pulses=%0d required 0", vcount - v0);
      end
   endtask

   task automatic test_multi_column();
      int v0 = vcount;
      logic [3:0] seen = 4'h0;
      krow = 2'd0; kmask = 4'b1001; kdown = 1'b1;
      repeat (8) begin
         wait_tick();
         seen = seen | ~row;
      end
      kdown = 1'b0;
      checks++;
      if (seen !== 4'hF) begin
         errors++; $display("FAIL multi_rotate: rows_seen=%b required 1111", seen);
      end
      checks++;
      if (vcount != v0) begin
         errors++; $display("FAIL multi_pulse: pulses=%0d required 0", vcount - v0);
      end
   endtask

   task automatic clear_digits();
      digit_clr = 1'b1;
      step();
      digit_clr = 1'b0;
      checks++;
      if (digits !== 32'h0) begin
         errors++; $display("FAIL digit_clr: digits=%h required 0", digits);
      end
   endtask

   task automatic test_sequence();
      clear_digits();
      press_key(2'd0, 4'b1110, 4'h1);
      press_key(2'd0, 4'b1101, 4'h2);
      press_key(2'd0, 4'b1011, 4'h3);
      press_key(2'd0, 4'b0111, 4'hA);
      checks++;
      if (digits !== 32'h0000123A) begin
         errors++; $display("FAIL seq_4: digits=%h required 0000123a", digits);
      end
      clear_digits();
      for (int i = 0; i < 9; i++) begin
         press_key(2'(i / 3), ~(4'b0001 << (i % 3)), 4'(i + 1));
      end
      checks++;
      if (digits !== 32'h23456789) begin
         errors++; $display("FAIL seq_9: digits=%h required 23456789", digits);
      end
      press_key(2'd3, 4'b1110, 4'hE);
      press_key(2'd3, 4'b1011, 4'hF);
      checks++;
      if (digits !== 32'h456789EF) begin
         errors++; $display("FAIL seq_star_hash: digits=%h required 456789ef", digits);
      end
   endtask

   task automatic test_clear_collision();
      int v0 = vcount;
      int n = 0;
      krow = 2'd1; kmask = 4'b1101; kdown = 1'b1;
      while (vcount == v0 && n < 300) begin
         step();
         n++;
      end
      digit_clr = 1'b1;
      step();
      digit_clr = 1'b0;
      step();
      checks++;
      if (digits !== 32'h0) begin
         errors++; $display("FAIL collide_digits: digits=%h required 0", digits);
      end
      checks++;
      if (key_code !== 4'h5 || vcount != v0 + 1) begin
         errors++;
         $display("FAIL collide_code: code=%h pulses=%0d required 5 1", key_code, vcount - v0);
      end
      wait_tick();
      kdown = 1'b0;
      repeat (6) wait_tick();
   endtask

   task automatic test_reset_mid_debounce();
      int v0;
      int n = 0;
      wait_row(2'd2);
      krow = 2'd2; kmask = 4'b1101; kdown = 1'b1;
      repeat (2) wait_tick();
      v0 = vcount;
      clr_n = 1'b0;
      #1;
      checks++;
      if (row !== 4'b1110 || key_held !== 1'b0 || digits !== 32'h0) begin
         errors++;
         $display("FAIL reset_async: row=%b held=%b digits=%h required 1110 0 0",
                  row, key_held, digits);
      end
      repeat (2) step();
      clr_n = 1'b1;
      repeat (5) wait_tick();
      checks++;
      if (vcount != v0) begin
         errors++; $display("FAIL reset_no_pulse: pulses=%0d required 0", vcount - v0);
      end
      while (vcount == v0 && n < 40) begin
         step();
         n++;
      end
      step();
      checks++;
      if (vcount != v0 + 1 || key_code !== 4'h8 || digits !== 32'h00000008) begin
         errors++;
         $display("FAIL reset_repress: pulses=%0d code=%h digits=%h required 1 8 00000008",
                  vcount - v0, key_code, digits);
      end
      wait_tick();
      kdown = 1'b0;
      repeat (6) wait_tick();
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_multi_column();
      test_sequence();
      test_clear_collision();
      test_reset_mid_debounce();
      checks++;
      if (wide != 0) begin
         errors++; $display("FAIL pulse_width: wide_cycles=%0d required 0", wide);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 hex matrix keypad and feeds the seven-segment display path. Drives one keypad row low at a time, samples the four column inputs, and debounces a single pressed key. It then emits a one-cycle key strobe with a 4-bit hex code. Accepted keys are shifted into a 32-bit, 8-nibble digit register whose format is the display driver's `in` bus: digit 0 is in bits [3:0].

## Interface
- `DIV_W`, default 18: scan-tick divider width; one tick every 2^DIV_W clocks.
- `DEBOUNCE_CNT`, default 4: consecutive matching ticks needed to accept a press or a release; must be ≥2.
- `clk`  in  1  system clock.
- `clr_n`  in  1  reset, asynchronous assert, active-low.
- `col`  in  4  keypad columns, active-low, pulled up externally, asynchronous to `clk`.
- `digit_clr`  in  1  synchronous active-high clear of `digits`.
- `row`  out  4  keypad row drive, active-low, exactly one bit low at all times.
- `key_valid`  out  1  one-cycle pulse per accepted key press.
- `key_code`  out  4  hex code of the last accepted key; held until the next accepted key.
- `key_held`  out  1  high from the `key_valid` cycle until the release is debounced.
- `digits`  out  32  eight most recent key codes; newest in [3:0].

## Operation
- **Clocking and reset:** single clock `clk`. `clr_n` is asynchronous, active-low.
- **Column synchroniser:** `col` passes through a 2-flop synchroniser to give `col_s`. All decisions use `col_s`.
- **Divider:** free-running DIV_W-bit counter. `tick` is high for one clock when the counter is all ones; the counter wraps to 0.
- **Row drive:** `row_idx` (2 bits) sets `row = ~(4'b0001 << row_idx)`.
- **FSM states:** SCAN, DEBOUNCE, PRESSED, RELEASE. Only `tick` cycles cause transitions or counter updates.
  - **SCAN**
    - On tick, if `col_s` has exactly one low bit: latch `row_idx` and the column index, clear `cnt`, go to DEBOUNCE. `row_idx` is frozen.
    - On tick, if `col_s` is all high or has two or more low bits: `row_idx` increments, wrapping 3→0.
  - **DEBOUNCE**
    - On tick, if `col_s` equals the latched pattern, `cnt` increments.
    - When `cnt` reaches DEBOUNCE_CNT-1 on a matching tick: go to PRESSED. In the next cycle assert `key_valid`, update `key_code`, set `key_held`, and shift `digits`.
    - On a mismatching tick: go to SCAN and advance `row_idx`.
  - **PRESSED**
    - On tick with `col_s` all high: clear `cnt`, go to RELEASE.
    - Any other tick: stay in PRESSED.
  - **RELEASE**
    - On tick with `col_s` all high: `cnt` increments. When `cnt` reaches DEBOUNCE_CNT-1, clear `key_held`, go to SCAN and advance `row_idx`.
    - On tick with any column low: go to PRESSED.
- **Key map** (row, col → code):
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: E (`*`), 0, F (`#`), D
- **Digit register:** on `key_valid`, `digits <= {digits[27:0], key_code_new}`. The oldest nibble is discarded.
- **`digit_clr` priority:** `digit_clr` has priority over the shift. If both occur in the same cycle, `digits` becomes 0. `key_valid` and `key_code` are unaffected.
- **Reset values:**
  - FSM = SCAN, `row_idx` = 0, so `row` = 4'b1110.
  - Divider and `cnt` = 0.
  - `key_valid` = 0, `key_code` = 0, `key_held` = 0, `digits` = 0.
  - Synchroniser flops = 4'hF.
- **Reset mid-operation:** discards any press in progress. After reset deasserts, a key that is still held needs a full SCAN→DEBOUNCE sequence before it produces a pulse.

## Timing
- **Row settling:** `row` changes on the tick edge. Columns are next evaluated one full divider period later.
- **Press latency:** stable press → `key_valid` = 2 clocks of synchronisation + up to 4 ticks to reach the row + DEBOUNCE_CNT ticks + 1 clock.
- **Pulse width:** `key_valid` is exactly 1 clock wide, and never more than once per press.
- **Registered outputs:** all outputs come directly from flops, with no combinational paths from input to output.

## Structure
- **Package `keypad_pkg`:**
  - FSM state enum.
  - 16-entry key-map constant array indexed by {row, col}.
  - Codes for the `*` and `#` keys.
- **Sub-module `sync2`:** the generic 2-flop synchroniser, parameterised by width.

## Test plan
- **Reset:** hold `clr_n`=0 → `row`=4'b1110, `digits`=0, `key_valid`=0, `key_held`=0. Reset asserted mid-tick is seen immediately.
- **Single press** (`DIV_W`=4, `DEBOUNCE_CNT`=4): press row 1 / col 2, i.e. `col`=4'b1011 while `row`=4'b1101 → exactly one `key_valid`, `key_code`=6, `digits`=32'h00000006. `key_held` drops 4 ticks after release.
- **Bounce:** column low for 2 ticks then high → no `key_valid`, and scanning resumes on the next row.
- **Sequence:** keys 1, 2, 3, A → `digits`=32'h0000123A. Nine keys 1–9 → `digits`=32'h23456789.
- **Multi-column press:** `col`=4'b1001 → no `key_valid`, and `row` keeps rotating.
- **Clear collision:** `digit_clr` in the same cycle as `key_valid` → `digits`=0 and `key_code` is updated. Separately, `clr_n` pulsed during DEBOUNCE → no pulse is produced by that press.
